// File: rtl/camera_strip_capture_pkg.sv
`default_nettype none
// ============================================================================
// jfpjc_capture_pkg : shared types and sizing for camera_strip_capture
// Revision 1.0
// ============================================================================
package jfpjc_capture_pkg;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      ACTIVE     = 2'd1,
      DROP       = 2'd2
   } state_e;

   localparam int STRIP_ROWS = 8;

   // Strip RAM address width: two banks of STRIP_ROWS lines each.
   function automatic int addr_width(input int width);
      return $clog2(2 * STRIP_ROWS * width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/camera_strip_capture_if.sv
`default_nettype none
// ============================================================================
// camera_strip_capture_if : strip RAM write port and consumer handshake
// Revision 1.0
// ============================================================================
interface camera_strip_capture_if #(
   parameter int WIDTH = 320
) ();
   import jfpjc_capture_pkg::*;

   localparam int AW = addr_width(WIDTH);

   logic          strip_release;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          strip_done;
   logic          strip_bank;
   logic          frame_start;
   logic          frame_done;
   logic          overflow;

   modport master (
      input  strip_release,
      output wr_en, wr_addr, wr_data, strip_done, strip_bank,
      output frame_start, frame_done, overflow
   );

   modport slave (
      output strip_release,
      input  wr_en, wr_addr, wr_data, strip_done, strip_bank,
      input  frame_start, frame_done, overflow
   );

endinterface
`default_nettype wire

// File: rtl/camera_strip_capture_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// sync_edge_detect : multi-flop synchronizer with registered level/rise/fall
// Revision 1.0
// ============================================================================
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic              level_q, level_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   always_comb begin
      sync_d  = {sync_q[STAGES-2:0], d};
      level_d = sync_q[STAGES-1];
      rise_d  = sync_q[STAGES-1] & ~level_q;
      fall_d  = ~sync_q[STAGES-1] & level_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/camera_strip_capture.sv
`default_nettype none
// ============================================================================
// camera_strip_capture : async camera capture into ping-pong 8-row strip banks
// Revision 1.0
// ============================================================================
module camera_strip_capture #(
   parameter int WIDTH       = 320,
   parameter int HEIGHT      = 240,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pixclk_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic [7:0]            pixel_in,
   camera_strip_capture_if.master strip
);
   import jfpjc_capture_pkg::*;

   localparam int                C_AW    = addr_width(WIDTH);
   localparam int                C_XW    = $clog2(WIDTH + 1);
   localparam logic [C_XW-1:0]   C_XMAX  = C_XW'(WIDTH);
   localparam logic [C_AW-2:0]   C_WIDTH = (C_AW-1)'(WIDTH);
   localparam logic [2:0]        C_LAST_ROW = 3'(STRIP_ROWS - 1);

   if ((WIDTH % 8) != 0 || (HEIGHT % 8) != 0 || SYNC_STAGES < 2) begin : g_param_check
      $error("camera_strip_capture: WIDTH/HEIGHT must be multiples of 8, SYNC_STAGES >= 2");
   end

   logic pix_level, pix_rise, pix_fall;
   logic hs_level, hs_rise, hs_fall;
   logic vs_level, vs_rise, vs_fall;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_pix_sync (
      .clock(clock), .reset(reset), .d(pixclk_in),
      .level(pix_level), .rise(pix_rise), .fall(pix_fall)
   );
   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_hs_sync (
      .clock(clock), .reset(reset), .d(hsync_in),
      .level(hs_level), .rise(hs_rise), .fall(hs_fall)
   );
   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_vs_sync (
      .clock(clock), .reset(reset), .d(vsync_in),
      .level(vs_level), .rise(vs_rise), .fall(vs_fall)
   );

   logic w_unused;
   assign w_unused = pix_level ^ pix_fall ^ hs_rise;

   // Pixel byte travels SYNC_STAGES+1 flops so it lines up with the registered strobe.
   logic [SYNC_STAGES:0][7:0] pix_dly_q, pix_dly_d;

   state_e          state_q, state_d;
   logic [C_XW-1:0] x_q, x_d;
   logic [2:0]      row_q, row_d;
   logic            wbank_q, wbank_d;
   logic [1:0]      full_q, full_d;
   logic            oldest_q, oldest_d;
   logic            overflow_q, overflow_d;
   logic            wr_en_q, wr_en_d;
   logic [C_AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            strip_done_q, strip_done_d;
   logic            strip_bank_q, strip_bank_d;
   logic            frame_start_q, frame_start_d;
   logic            frame_done_q, frame_done_d;

   logic            w_line_pix, w_line_end;
   logic [C_AW-2:0] w_low;

   // A strobe coinciding with the hsync fall still belongs to the closing line.
   assign w_line_pix = pix_rise & (hs_level | hs_fall) & vs_level;
   assign w_line_end = hs_fall & ((x_q != '0) | w_line_pix);
   assign w_low      = (C_AW-1)'(row_q) * C_WIDTH + (C_AW-1)'(x_q);

   always_comb begin
      pix_dly_d     = {pix_dly_q[SYNC_STAGES-1:0], pixel_in};
      state_d       = state_q;
      x_d           = x_q;
      row_d         = row_q;
      wbank_d       = wbank_q;
      full_d        = full_q;
      oldest_d      = oldest_q;
      overflow_d    = overflow_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      strip_done_d  = 1'b0;
      strip_bank_d  = strip_bank_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;

      // Release lands before any completion so a finishing strip can reuse the bank.
      if (strip.strip_release && (full_q != 2'b00)) begin
         full_d[oldest_q] = 1'b0;
         oldest_d         = ~oldest_q;
      end

      case (state_q)
         WAIT_FRAME: begin
            if (vs_rise) begin
               frame_start_d = 1'b1;
               x_d           = '0;
               row_d         = '0;
               overflow_d    = 1'b0;
               if (full_d[wbank_q]) begin
                  overflow_d = 1'b1;
                  state_d    = DROP;
               end else begin
                  state_d = ACTIVE;
               end
            end
         end
         ACTIVE, DROP: begin
            if (vs_fall) begin
               frame_done_d = 1'b1;
               x_d          = '0;
               row_d        = '0;
               state_d      = WAIT_FRAME;
            end else begin
               if (w_line_pix && (x_q < C_XMAX)) begin
                  if (state_q == ACTIVE) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = {wbank_q, w_low};
                     wr_data_d = pix_dly_q[SYNC_STAGES];
                  end
                  x_d = x_q + 1'b1;
               end
               if (w_line_end) begin
                  x_d = '0;
                  if (row_q == C_LAST_ROW) begin
                     row_d = '0;
                     if (state_q == ACTIVE) begin
                        full_d[wbank_q] = 1'b1;
                        strip_done_d    = 1'b1;
                        strip_bank_d    = wbank_q;
                        wbank_d         = ~wbank_q;
                        if (full_d[~wbank_q]) begin
                           overflow_d = 1'b1;
                           state_d    = DROP;
                        end
                     end else if (!full_d[wbank_q]) begin
                        state_d = ACTIVE;
                     end
                  end else begin
                     row_d = row_q + 3'd1;
                  end
               end
            end
         end
         default: state_d = WAIT_FRAME;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pix_dly_q     <= '0;
         state_q       <= WAIT_FRAME;
         x_q           <= '0;
         row_q         <= '0;
         wbank_q       <= 1'b0;
         full_q        <= 2'b00;
         oldest_q      <= 1'b0;
         overflow_q    <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         strip_done_q  <= 1'b0;
         strip_bank_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         pix_dly_q     <= pix_dly_d;
         state_q       <= state_d;
         x_q           <= x_d;
         row_q         <= row_d;
         wbank_q       <= wbank_d;
         full_q        <= full_d;
         oldest_q      <= oldest_d;
         overflow_q    <= overflow_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         strip_done_q  <= strip_done_d;
         strip_bank_q  <= strip_bank_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign strip.wr_en       = wr_en_q;
   assign strip.wr_addr     = wr_addr_q;
   assign strip.wr_data     = wr_data_q;
   assign strip.strip_done  = strip_done_q;
   assign strip.strip_bank  = strip_bank_q;
   assign strip.frame_start = frame_start_q;
   assign strip.frame_done  = frame_done_q;
   assign strip.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_strip_capture.sv
`default_nettype none
// ============================================================================
// tb_camera_strip_capture : directed/randomized bench with line-level model
// Revision 1.0
// ============================================================================
module tb_camera_strip_capture;
   import jfpjc_capture_pkg::*;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int SS = 2;
   localparam int AW = addr_width(W);

   logic       clock = 1'b0;
   logic       reset;
   logic       pixclk_in, hsync_in, vsync_in;
   logic [7:0] pixel_in;

   camera_strip_capture_if #(.WIDTH(W)) bus ();

   camera_strip_capture #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(SS)) dut (
      .clock    (clock),
      .reset    (reset),
      .pixclk_in(pixclk_in),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .pixel_in (pixel_in),
      .strip    (bus)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   // Observed traffic
   int         got_addr[$];
   int         got_data[$];
   int         got_strip[$];
   int         fs_cnt = 0;
   int         fd_cnt = 0;
   logic [7:0] mem [0:(1<<AW)-1];

   always @(negedge clock) begin
      if (!reset) begin
         if (bus.wr_en) begin
            got_addr.push_back(int'(bus.wr_addr));
            got_data.push_back(int'(bus.wr_data));
            mem[bus.wr_addr] = bus.wr_data;
         end
         if (bus.strip_done)  got_strip.push_back(int'(bus.strip_bank));
         if (bus.frame_start) fs_cnt++;
         if (bus.frame_done)  fd_cnt++;
      end
   end

   // Line-level reference model
   int         m_full[2];
   int         m_oldest, m_wbank, m_row, m_overflow, m_drop;
   int         exp_addr[$];
   int         exp_data[$];
   int         exp_strip[$];
   int         exp_fs = 0;
   int         exp_fd = 0;
   logic [7:0] line_pix [0:31];

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_full[0] = 0; m_full[1] = 0;
      m_oldest = 0; m_wbank = 0; m_row = 0; m_overflow = 0; m_drop = 0;
      exp_addr.delete(); exp_data.delete(); exp_strip.delete();
      got_addr.delete(); got_data.delete(); got_strip.delete();
      exp_fs = 0; exp_fd = 0; fs_cnt = 0; fd_cnt = 0;
   endtask

   task automatic model_release();
      if (m_full[0] != 0 || m_full[1] != 0) begin
         m_full[m_oldest] = 0;
         m_oldest ^= 1;
      end
   endtask

   task automatic model_pixels(input int npix);
      if (!m_drop)
         for (int i = 0; i < npix && i < W; i++) begin
            exp_addr.push_back(m_wbank * STRIP_ROWS * W + m_row * W + i);
            exp_data.push_back(int'(line_pix[i]));
         end
   endtask

   task automatic model_line(input int npix);
      model_pixels(npix);
      if (npix > 0) begin
         if (m_row == STRIP_ROWS - 1) begin
            m_row = 0;
            if (!m_drop) begin
               m_full[m_wbank] = 1;
               exp_strip.push_back(m_wbank);
               m_wbank ^= 1;
               if (m_full[m_wbank] != 0) begin
                  m_overflow = 1;
                  m_drop     = 1;
               end
            end else if (m_full[m_wbank] == 0) begin
               m_drop = 0;
            end
         end else begin
            m_row++;
         end
      end
   endtask

   task automatic drive_pixels(input int npix);
      for (int i = 0; i < npix; i++) begin
         pixel_in = line_pix[i];
         tick(2);
         pixclk_in = 1'b1;
         tick(4);
         pixclk_in = 1'b0;
         tick(2);
      end
   endtask

   task automatic fill_line(input int npix, input bit pattern, input int y);
      for (int i = 0; i < npix; i++)
         line_pix[i] = pattern ? 8'(i + 16 * y) : 8'($urandom);
   endtask

   task automatic do_line(input int npix, input bit rel, input bit pattern, input int y);
      fill_line(npix, pattern, y);
      if (rel) model_release();
      model_line(npix);
      hsync_in = 1'b1;
      tick(4);
      drive_pixels(npix);
      hsync_in = 1'b0;
      if (rel) begin
         tick(3);
         bus.strip_release = 1'b1;
         tick(1);
         bus.strip_release = 1'b0;
      end
      tick(6 + $urandom_range(0, 4));
   endtask

   task automatic do_release();
      model_release();
      bus.strip_release = 1'b1;
      tick(1);
      bus.strip_release = 1'b0;
      tick(2);
   endtask

   task automatic frame_begin();
      vsync_in = 1'b1;
      exp_fs++;
      m_row = 0;
      m_overflow = 0;
      m_drop = m_full[m_wbank];
      if (m_drop != 0) m_overflow = 1;
      tick(6);
   endtask

   task automatic frame_end();
      vsync_in = 1'b0;
      exp_fd++;
      m_drop = 0;
      tick(10);
   endtask

   task automatic check_all(input string tag);
      int n;
      tick(8);
      chk({tag, "_nwr"}, got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_addr"}, got_addr[i], exp_addr[i]);
         chk({tag, "_data"}, got_data[i], exp_data[i]);
      end
      chk({tag, "_nstrip"}, got_strip.size(), exp_strip.size());
      n = (got_strip.size() < exp_strip.size()) ? got_strip.size() : exp_strip.size();
      for (int i = 0; i < n; i++) chk({tag, "_bank"}, got_strip[i], exp_strip[i]);
      chk({tag, "_fstart"}, fs_cnt, exp_fs);
      chk({tag, "_fdone"}, fd_cnt, exp_fd);
      chk({tag, "_ovf"}, bus.overflow, m_overflow);
      got_addr.delete(); got_data.delete(); got_strip.delete();
      exp_addr.delete(); exp_data.delete(); exp_strip.delete();
      fs_cnt = 0; fd_cnt = 0; exp_fs = 0; exp_fd = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_wr_en"},   bus.wr_en, 0);
      chk({tag, "_wr_addr"}, bus.wr_addr, 0);
      chk({tag, "_wr_data"}, bus.wr_data, 0);
      chk({tag, "_sdone"},   bus.strip_done, 0);
      chk({tag, "_sbank"},   bus.strip_bank, 0);
      chk({tag, "_fstart"},  bus.frame_start, 0);
      chk({tag, "_fdone"},   bus.frame_done, 0);
      chk({tag, "_ovf"},     bus.overflow, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      pixclk_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; pixel_in = 8'h00;
      bus.strip_release = 1'b0;
      model_reset();
      tick(4);
      check_outputs_zero("rst");
      reset = 1'b0;
      tick(4);

      // Release with no full bank must be ignored
      do_release();

      // T1: 16x16 ramp frame, release after each strip
      frame_begin();
      for (int y = 0; y < 16; y++) begin
         do_line(W, 1'b0, 1'b1, y);
         if (y % 8 == 7) do_release();
      end
      frame_end();
      chk("t1_last_px", mem[(1 << AW) - 1], 8'hFF);
      check_all("t1");

      // T2: 24 lines, no releases -> third strip dropped
      frame_begin();
      for (int y = 0; y < 24; y++) begin
         do_line(W, 1'b0, 1'b0, y);
         if (y == 15) chk("t2_ovf_set", bus.overflow, 1);
      end
      frame_end();
      check_all("t2");
      do_release();
      do_release();

      // T3: release coincident with 8th-row completion while other bank is full
      frame_begin();
      chk("t3_ovf_clear", bus.overflow, 0);
      for (int y = 0; y < 24; y++) begin
         do_line(W, (y == 15), 1'b0, y);
         if (y == 15) chk("t3_no_ovf", bus.overflow, 0);
         if (y == 16) do_release();
      end
      frame_end();
      do_release();
      check_all("t3");

      // T4: frame aborted after 11 lines
      frame_begin();
      for (int y = 0; y < 11; y++) do_line(W, 1'b0, 1'b0, y);
      frame_end();
      check_all("t4");
      do_release();

      // T5: overlong lines, frame restarts at row 0 of current bank
      frame_begin();
      for (int y = 0; y < 8; y++)
         do_line((y == 0) ? 20 : W + int'($urandom_range(1, 8)), 1'b0, 1'b0, y);
      chk("t5_first_addr", (got_addr.size() > 0) ? got_addr[0] : 32'hFFFF_FFFF, 0);
      frame_end();
      check_all("t5");
      do_release();

      // T6: reset mid-line at row 3, x 5
      frame_begin();
      for (int y = 0; y < 3; y++) do_line(W, 1'b0, 1'b0, y);
      fill_line(5, 1'b0, 3);
      model_pixels(5);
      hsync_in = 1'b1;
      tick(4);
      drive_pixels(5);
      check_all("t6a");
      reset = 1'b1;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      tick(2);
      check_outputs_zero("t6_rst");
      reset = 1'b0;
      model_reset();
      tick(6);
      frame_begin();
      for (int y = 0; y < 8; y++) do_line(W, 1'b0, 1'b0, y);
      chk("t6_first_addr", (got_addr.size() > 0) ? got_addr[0] : 32'hFFFF_FFFF, 0);
      frame_end();
      check_all("t6b");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
